// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: walks NandMUX selects a..d, samples w per channel.
// Optional MUX_SCAN_AUTO_EN adds an auto port for back-to-back scans.
module mux_scan_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       w,
`ifdef MUX_SCAN_AUTO_EN
  input  logic       auto,
`endif
  output logic       s0,
  output logic       s1,
  output logic [3:0] sample,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state, state_n;
  logic [1:0] idx, idx_n;
  logic [3:0] cnt, cnt_n;
  logic [3:0] shadow, shadow_n;
  logic [3:0] sample_n;
  logic       rescan;

`ifdef MUX_SCAN_AUTO_EN
  assign rescan = auto;
`else
  assign rescan = 1'b0;
`endif

  // state, scan registers and output flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= 2'd0;
      cnt    <= 4'd0;
      shadow <= 4'd0;
      sample <= 4'd0;
      s0     <= 1'b0;
      s1     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      cnt    <= cnt_n;
      shadow <= shadow_n;
      sample <= sample_n;
      s0     <= (state_n == SETTLE) & idx_n[1];
      s1     <= (state_n == SETTLE) & idx_n[0];
      busy   <= (state_n == SETTLE);
      done   <= (state_n == DONE);
    end
  end

  // next-state: settle count, capture, publish whole word on last channel
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    cnt_n    = cnt;
    shadow_n = shadow;
    sample_n = sample;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = SETTLE;
          idx_n   = 2'd0;
          cnt_n   = 4'd0;
        end
      end
      SETTLE: begin
        if (cnt == CNT_LAST) begin
          cnt_n         = 4'd0;
          shadow_n[idx] = w;
          if (idx == 2'd3) begin
            sample_n = {w, shadow[2:0]};
            state_n  = DONE;
          end else begin
            idx_n = idx + 2'd1;
          end
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      DONE: begin
        idx_n   = 2'd0;
        cnt_n   = 4'd0;
        state_n = rescan ? SETTLE : IDLE;
      end
      default: begin
        state_n = IDLE;
        idx_n   = 2'd0;
        cnt_n   = 4'd0;
      end
    endcase
  end

endmodule
